// File: rtl/l2_cache.sv
`default_nettype none
// ============================================================================
//  Module   : l2_cache
//  Brief    : Direct-mapped, write-through / write-allocate second-level cache
//             with an integrated main-memory model, fixed hit and memory
//             latencies, single outstanding request over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module l2_cache #(
   parameter int WORD_SIZE = 32,
   parameter int L2_DELAY  = 3,
   parameter int MEM_DELAY = 8,
   parameter int LINES     = 16,
   parameter int MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [WORD_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_hit
);

   localparam int IDX_W     = $clog2(LINES);
   localparam int MEM_AW    = $clog2(MEM_DEPTH);
   localparam int TAG_W     = MEM_AW - IDX_W;
   localparam int MAX_DELAY = (L2_DELAY > MEM_DELAY) ? L2_DELAY : MEM_DELAY;
   localparam int CNT_W     = (MAX_DELAY < 2) ? 1 : $clog2(MAX_DELAY + 1);

   localparam logic [CNT_W-1:0] L2_LOAD  = CNT_W'(L2_DELAY - 1);
   localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_MEM    = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 wr_q;
   logic [MEM_AW-1:0]    addr_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic                 hit_q;
   logic [WORD_SIZE-1:0] rdata_q;
   logic                 resp_hit_q;

   logic                 valid_q [LINES];
   logic [TAG_W-1:0]     tag_q   [LINES];
   logic [WORD_SIZE-1:0] data_q  [LINES];
   logic [WORD_SIZE-1:0] mem_q   [MEM_DEPTH];

   // Upper address bits alias onto the backing memory and carry no meaning.
   logic                 unused_addr_bits;
   assign unused_addr_bits = ^req_addr[WORD_SIZE-1:MEM_AW];

   logic [IDX_W-1:0]     req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic                 lookup_hit;
   logic [IDX_W-1:0]     cur_idx;
   logic [TAG_W-1:0]     cur_tag;
   logic                 cnt_done;
   logic                 accept;

   assign req_idx    = req_addr[IDX_W-1:0];
   assign req_tag    = req_addr[MEM_AW-1:IDX_W];
   assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign cur_idx    = addr_q[IDX_W-1:0];
   assign cur_tag    = addr_q[MEM_AW-1:IDX_W];
   assign cnt_done   = (cnt_q == CNT_ZERO);
   assign accept     = req_valid && (state_q == S_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: read hits skip the memory phase, writes never do.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req_valid) state_d = S_LOOKUP;
         S_LOOKUP: if (cnt_done) state_d = (!wr_q && hit_q) ? S_RESP : S_MEM;
         S_MEM:    if (cnt_done) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode: ready only when idle, response strobe for the RESP cycle.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
   end

   assign resp_rdata = rdata_q;
   assign resp_hit   = resp_hit_q;

   // Datapath: request capture, latency counter, line array and memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= CNT_ZERO;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hit_q      <= 1'b0;
         rdata_q    <= '0;
         resp_hit_q <= 1'b0;
         for (int i = 0; i < LINES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
         for (int j = 0; j < MEM_DEPTH; j++) begin
            mem_q[j] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  wr_q    <= req_wr;
                  addr_q  <= req_addr[MEM_AW-1:0];
                  wdata_q <= req_wdata;
                  // Residency is decided once, at lookup entry.
                  hit_q   <= lookup_hit;
                  cnt_q   <= L2_LOAD;
               end
            end
            S_LOOKUP: begin
               if (cnt_done) begin
                  if (!wr_q && hit_q) begin
                     rdata_q    <= data_q[cur_idx];
                     resp_hit_q <= 1'b1;
                  end else begin
                     cnt_q <= MEM_LOAD;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_MEM: begin
               if (cnt_done) begin
                  valid_q[cur_idx] <= 1'b1;
                  tag_q[cur_idx]   <= cur_tag;
                  resp_hit_q       <= hit_q;
                  if (wr_q) begin
                     mem_q[addr_q]   <= wdata_q;
                     data_q[cur_idx] <= wdata_q;
                     rdata_q         <= wdata_q;
                  end else begin
                     data_q[cur_idx] <= mem_q[addr_q];
                     rdata_q         <= mem_q[addr_q];
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l2_cache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_cache
//  Brief    : Self-checking bench for l2_cache: directed scenarios followed by
//             random traffic, compared against a behavioural cache/memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_cache;

   localparam int WS    = 32;
   localparam int L2D   = 3;
   localparam int MEMD  = 8;
   localparam int NLINE = 16;
   localparam int DEPTH = 256;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_wr;
   logic [WS-1:0] req_addr;
   logic [WS-1:0] req_wdata;
   logic          resp_valid;
   logic [WS-1:0] resp_rdata;
   logic          resp_hit;

   int checks;
   int errors;

   // Reference model: memory contents plus which tag each line holds.
   logic [WS-1:0] m_mem [DEPTH];
   bit            m_val [NLINE];
   int            m_tag [NLINE];

   l2_cache #(
      .WORD_SIZE (WS),
      .L2_DELAY  (L2D),
      .MEM_DELAY (MEMD),
      .LINES     (NLINE),
      .MEM_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_hit   (resp_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int i = 0; i < NLINE; i++) begin
         m_val[i] = 1'b0;
         m_tag[i] = 0;
      end
   endtask

   // Predict data, residency and latency of one transaction and update state.
   task automatic model_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] ed, output bit eh, output int elat);
      int ma, idx, tg;
      ma  = int'(addr % DEPTH);
      idx = ma % NLINE;
      tg  = ma / NLINE;
      eh  = m_val[idx] && (m_tag[idx] == tg);
      if (wr) begin
         m_mem[ma] = wd;
         elat      = L2D + MEMD;
      end else begin
         elat = eh ? L2D : L2D + MEMD;
      end
      ed         = m_mem[ma];
      m_val[idx] = 1'b1;
      m_tag[idx] = tg;
   endtask

   // One complete transaction; optionally keep req_valid high with a held read.
   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, input logic [31:0] hold_addr);
      logic [31:0] ed;
      bit          eh;
      int          elat;
      int          n;
      bit          busy_bad;
      model_req(wr, addr, wd, ed, eh, elat);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_val("ready_wait_timeout", 32'd0, 32'd1);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk);
      #1;
      if (hold) begin
         req_wr    = 1'b0;
         req_addr  = hold_addr;
         req_wdata = $urandom;
      end else begin
         req_valid = 1'b0;
         req_wr    = 1'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
      end
      n        = 0;
      busy_bad = 1'b0;
      while (!resp_valid && n < 100) begin
         if (req_ready) busy_bad = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      check_val("latency", n, elat);
      check_val("busy_ready_low", {31'd0, busy_bad | req_ready}, 32'd0);
      check_val("resp_rdata", resp_rdata, ed);
      check_val("resp_hit", {31'd0, resp_hit}, {31'd0, eh});
      @(posedge clk);
      #1;
      check_val("post_ready", {31'd0, req_ready}, 32'd1);
      check_val("post_valid_low", {31'd0, resp_valid}, 32'd0);
      check_val("rdata_hold", resp_rdata, ed);
   endtask

   // Count stray response strobes over a window of idle cycles.
   task automatic expect_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid) seen++;
      end
      check_val(tag, seen, 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      bit          w;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", {31'd0, req_ready}, 32'd1);
      check_val("rst_valid", {31'd0, resp_valid}, 32'd0);
      check_val("rst_rdata", resp_rdata, 32'd0);
      check_val("rst_hit", {31'd0, resp_hit}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed scenarios.
      do_req(1'b1, 32'h10,  32'hA5A5A5A5, 1'b0, 32'h0);
      do_req(1'b0, 32'h10,  32'h0,        1'b0, 32'h0);
      do_req(1'b0, 32'h11,  32'h0,        1'b0, 32'h0);
      do_req(1'b0, 32'h11,  32'h0,        1'b0, 32'h0);
      do_req(1'b1, 32'h20,  32'h5A5A5A5A, 1'b0, 32'h0);
      do_req(1'b0, 32'h10,  32'h0,        1'b0, 32'h0);
      do_req(1'b0, 32'h110, 32'h0,        1'b0, 32'h0);

      // Held request while busy is taken exactly once, after returning idle.
      do_req(1'b0, 32'h20,  32'h0,        1'b1, 32'h20);
      do_req(1'b0, 32'h20,  32'h0,        1'b0, 32'h0);
      expect_quiet("held_single_accept", 15);

      // Reset in the memory phase of a write aborts it.
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 32'h30;
      req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("abort_valid_low", {31'd0, resp_valid}, 32'd0);
      check_val("abort_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      expect_quiet("abort_no_resp", 15);
      do_req(1'b0, 32'h30,  32'h0,        1'b0, 32'h0);
      do_req(1'b0, 32'h10,  32'h0,        1'b0, 32'h0);

      // Random traffic over a small, heavily aliasing address set.
      for (int k = 0; k < 60; k++) begin
         a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 4) |
             32'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) a = a | 32'hF000_0000;
         d = $urandom;
         w = ($urandom_range(0, 2) == 0);
         do_req(w, a, d, 1'b0, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
